writeback_stage: RTL and testbench

Consumer end of the decode-to-execute control bundle (input, wren, writeAd, ADR_MUX, write, PC_load) carried by the second decode pipeline register. Selects result data and performs the register-file write. Issues memory-write requests with an ack handshake and drives PC loads. Keeps a per-register pending scoreboard that decode uses for hazard stalls, and backpressures the pipeline while a memory write is outstanding.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 36 +++
 rtl/writeback_stage.sv | 171 +++++++++++++++++
 tb/tb_writeback_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its pending-write scoreboard.
package wb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wb_state_t;

  localparam logic ADR_SEL_PC  = 1'b0;
  localparam logic ADR_SEL_ALU = 1'b1;

  localparam int NREGS   = 8;
  localparam int RADDR_W = 3;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write bits: single set port and single clear port, set wins on collision.
// Latency: one cycle from set/clear request to o_pending; no backpressure.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_set_en,
  input  logic [RADDR_W-1:0] i_set_idx,
  input  logic               i_clr_en,
  input  logic [RADDR_W-1:0] i_clr_idx,
  output logic [NREGS-1:0]   o_pending
);

  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] r_pending;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/writeback_stage.sv
// Writeback: result select, rf write, PC load, memory-write handshake with timeout abort.
// Latency: 1 cycle to strobes, or request then ack+1; ready_OUT low while a memory write is outstanding.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              valid_IN,
  output logic              ready_OUT,
  input  logic              input_IN,
  input  logic              wren_IN,
  input  logic [2:0]        writeAd_IN,
  input  logic              ADR_MUX_IN,
  input  logic              write_IN,
  input  logic              PC_load_IN,
  input  logic [DATA_W-1:0] alu_result_IN,
  input  logic [DATA_W-1:0] input_port_IN,
  input  logic [DATA_W-1:0] store_data_IN,
  input  logic [DATA_W-1:0] pc_IN,
  output logic              mem_req_OUT,
  output logic [DATA_W-1:0] mem_addr_OUT,
  output logic [DATA_W-1:0] mem_wdata_OUT,
  input  logic              mem_ack_IN,
  output logic              rf_we_OUT,
  output logic [2:0]        rf_waddr_OUT,
  output logic [DATA_W-1:0] rf_wdata_OUT,
  output logic              pc_load_OUT,
  output logic [DATA_W-1:0] pc_target_OUT,
  output logic [7:0]        pending_OUT,
  output logic              mem_err_OUT,
  output logic [CNT_W-1:0]  retire_cnt_OUT
);

  localparam int TCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  wb_state_t         r_state;
  logic              r_mem_req;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rf_we;
  logic [2:0]        r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_pc_load;
  logic [DATA_W-1:0] r_pc_target;
  logic              r_def_wren;
  logic [2:0]        r_def_addr;
  logic [DATA_W-1:0] r_def_data;
  logic              r_def_pcl;
  logic [DATA_W-1:0] r_def_target;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_retire;

  logic              w_accept;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_mem_addr;
  logic              w_abort;
  logic              w_clr_en;
  logic [2:0]        w_clr_idx;

  assign ready_OUT  = (r_state == IDLE);
  assign w_accept   = valid_IN & ready_OUT;
  assign w_result   = input_IN ? input_port_IN : alu_result_IN;
  assign w_mem_addr = (ADR_MUX_IN == ADR_SEL_ALU) ? alu_result_IN : pc_IN;
  // Ack checked first, so an ack landing on the final wait cycle still completes the write.
  assign w_abort    = (r_state == MEM_WAIT) & ~mem_ack_IN & (r_tcnt == TCNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_pc_load    <= 1'b0;
      r_pc_target  <= '0;
      r_def_wren   <= 1'b0;
      r_def_addr   <= '0;
      r_def_data   <= '0;
      r_def_pcl    <= 1'b0;
      r_def_target <= '0;
      r_tcnt       <= '0;
      r_mem_err    <= 1'b0;
      r_retire     <= '0;
    end else begin
      r_rf_we   <= 1'b0;
      r_pc_load <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (write_IN) begin
              r_state      <= MEM_WAIT;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= w_mem_addr;
              r_mem_wdata  <= store_data_IN;
              r_def_wren   <= wren_IN;
              r_def_addr   <= writeAd_IN;
              r_def_data   <= w_result;
              r_def_pcl    <= PC_load_IN;
              r_def_target <= alu_result_IN;
              r_tcnt       <= '0;
            end else begin
              r_rf_we   <= wren_IN;
              r_pc_load <= PC_load_IN;
              if (wren_IN) begin
                r_rf_waddr <= writeAd_IN;
                r_rf_wdata <= w_result;
              end
              if (PC_load_IN) r_pc_target <= alu_result_IN;
              r_retire <= r_retire + CNT_W'(1);
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack_IN) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_rf_we   <= r_def_wren;
            r_pc_load <= r_def_pcl;
            if (r_def_wren) begin
              r_rf_waddr <= r_def_addr;
              r_rf_wdata <= r_def_data;
            end
            if (r_def_pcl) r_pc_target <= r_def_target;
            r_retire <= r_retire + CNT_W'(1);
          end else if (w_abort) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_mem_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // rf strobes and aborts never coincide: an abort cycle is always in MEM_WAIT, where no strobe is issued.
  assign w_clr_en  = r_rf_we | (w_abort & r_def_wren);
  assign w_clr_idx = w_abort ? r_def_addr : r_rf_waddr;

  wb_scoreboard u_scoreboard (
    .clk       (CLK),
    .rst_n     (RST_N),
    .i_set_en  (w_accept & wren_IN),
    .i_set_idx (writeAd_IN),
    .i_clr_en  (w_clr_en),
    .i_clr_idx (w_clr_idx),
    .o_pending (pending_OUT)
  );

  assign mem_req_OUT    = r_mem_req;
  assign mem_addr_OUT   = r_mem_addr;
  assign mem_wdata_OUT  = r_mem_wdata;
  assign rf_we_OUT      = r_rf_we;
  assign rf_waddr_OUT   = r_rf_waddr;
  assign rf_wdata_OUT   = r_rf_wdata;
  assign pc_load_OUT    = r_pc_load;
  assign pc_target_OUT  = r_pc_target;
  assign mem_err_OUT    = r_mem_err;
  assign retire_cnt_OUT = r_retire;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: transaction-level expectations queued at issue, checked by a monitor.
module tb_writeback_stage;

  localparam int DATA_W      = 8;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } rf_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         dur;
    bit         abort;
    bit         wren;
    logic [2:0] wa;
  } mem_exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       valid_IN = 1'b0, input_IN = 1'b0, wren_IN = 1'b0, ADR_MUX_IN = 1'b0;
  logic       write_IN = 1'b0, PC_load_IN = 1'b0, mem_ack_IN = 1'b0;
  logic [2:0] writeAd_IN = '0;
  logic [7:0] alu_result_IN = '0, input_port_IN = '0, store_data_IN = '0, pc_IN = '0;
  logic       ready_OUT, mem_req_OUT, rf_we_OUT, pc_load_OUT, mem_err_OUT;
  logic [7:0] mem_addr_OUT, mem_wdata_OUT, rf_wdata_OUT, pc_target_OUT, pending_OUT;
  logic [2:0] rf_waddr_OUT;
  logic [CNT_W-1:0] retire_cnt_OUT;

  always #5 CLK = ~CLK;

  writeback_stage #(.DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .valid_IN(valid_IN), .ready_OUT(ready_OUT),
    .input_IN(input_IN), .wren_IN(wren_IN), .writeAd_IN(writeAd_IN), .ADR_MUX_IN(ADR_MUX_IN),
    .write_IN(write_IN), .PC_load_IN(PC_load_IN), .alu_result_IN(alu_result_IN),
    .input_port_IN(input_port_IN), .store_data_IN(store_data_IN), .pc_IN(pc_IN),
    .mem_req_OUT(mem_req_OUT), .mem_addr_OUT(mem_addr_OUT), .mem_wdata_OUT(mem_wdata_OUT),
    .mem_ack_IN(mem_ack_IN), .rf_we_OUT(rf_we_OUT), .rf_waddr_OUT(rf_waddr_OUT),
    .rf_wdata_OUT(rf_wdata_OUT), .pc_load_OUT(pc_load_OUT), .pc_target_OUT(pc_target_OUT),
    .pending_OUT(pending_OUT), .mem_err_OUT(mem_err_OUT), .retire_cnt_OUT(retire_cnt_OUT)
  );

  int tests = 0;
  int fails = 0;

  rf_exp_t    rf_q[$];
  logic [7:0] pc_q[$];
  mem_exp_t   mem_q[$];
  int         ack_q[$];
  int         exp_retire = 0;
  bit         exp_err = 0;
  bit         mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bundle issue: waits for ready, drives one cycle's worth of inputs, and records what must come out.
  task automatic issue(input logic inp, input logic wren, input logic [2:0] wa, input logic adr,
                       input logic wr, input logic pcl, input logic [7:0] alu, input logic [7:0] port,
                       input logic [7:0] store, input logic [7:0] pc, input int d);
    int budget;
    logic [7:0] res;
    mem_exp_t me;
    budget = 0;
    @(posedge CLK); #2;
    while (!ready_OUT && budget < 200) begin
      @(posedge CLK); #2;
      budget++;
    end
    if (!ready_OUT) begin
      chk("ready_wait_timeout", 32'(ready_OUT), 32'd1);
      return;
    end
    valid_IN = 1'b1; input_IN = inp; wren_IN = wren; writeAd_IN = wa; ADR_MUX_IN = adr;
    write_IN = wr; PC_load_IN = pcl; alu_result_IN = alu; input_port_IN = port;
    store_data_IN = store; pc_IN = pc;
    res = inp ? port : alu;
    if (!wr) begin
      if (wren) rf_q.push_back(rf_exp_t'{wa, res});
      if (pcl) pc_q.push_back(alu);
      exp_retire++;
    end else begin
      me.addr = adr ? alu : pc;
      me.data = store;
      me.wren = wren;
      me.wa   = wa;
      ack_q.push_back(d);
      if (d >= 0 && d < MEM_TIMEOUT) begin
        me.dur = d + 1; me.abort = 0;
        if (wren) rf_q.push_back(rf_exp_t'{wa, res});
        if (pcl) pc_q.push_back(alu);
        exp_retire++;
      end else begin
        me.dur = MEM_TIMEOUT; me.abort = 1;
      end
      mem_q.push_back(me);
    end
  endtask

  task automatic idle();
    @(posedge CLK); #2;
    valid_IN = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rf_q.size() != 0 || pc_q.size() != 0 || mem_q.size() != 0 || !ready_OUT) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(rf_q.size() + pc_q.size() + mem_q.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  // Memory responder: acks after the planned number of un-acked wait cycles (negative = never).
  initial begin
    bit in_txn;
    int cur_d, wcnt;
    in_txn = 0; cur_d = -1; wcnt = 0;
    forever begin
      @(posedge CLK); #2;
      mem_ack_IN = 1'b0;
      if (mem_req_OUT) begin
        if (!in_txn) begin
          in_txn = 1; wcnt = 0;
          cur_d = (ack_q.size() != 0) ? ack_q.pop_front() : -1;
        end
        if (cur_d >= 0 && wcnt == cur_d) mem_ack_IN = 1'b1;
        wcnt++;
      end else begin
        in_txn = 0;
      end
    end
  end

  // Monitor: outstanding-write counts per register give the expected pending vector.
  int         outst[8];
  bit         p_acc, p_wren, p_rfwe, p_req, unstable;
  logic [2:0] p_wa, p_rfa;
  int         mlen;
  mem_exp_t   cur;

  always @(negedge CLK) begin
    if (mon_en) begin
      logic [7:0] exp_p;
      if (p_acc && p_wren) outst[p_wa]++;
      if (p_rfwe) outst[p_rfa]--;
      if (mem_req_OUT && !p_req) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_req", 32'(mem_req_OUT), 32'd0);
        end else begin
          cur = mem_q.pop_front();
          chk("mem_addr", 32'(mem_addr_OUT), 32'(cur.addr));
          chk("mem_wdata", 32'(mem_wdata_OUT), 32'(cur.data));
          mlen = 1; unstable = 0;
        end
      end else if (mem_req_OUT) begin
        mlen++;
        if (mem_addr_OUT !== cur.addr || mem_wdata_OUT !== cur.data) unstable = 1;
      end else if (p_req) begin
        chk("mem_req_len", 32'(mlen), 32'(cur.dur));
        chk("mem_stable", 32'(unstable), 32'd0);
        if (cur.abort) begin
          exp_err = 1;
          if (cur.wren) outst[cur.wa]--;
        end
      end
      if (rf_we_OUT) begin
        if (rf_q.size() == 0) begin
          chk("rf_unexpected_we", 32'(rf_we_OUT), 32'd0);
        end else begin
          rf_exp_t e;
          e = rf_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr_OUT), 32'(e.a));
          chk("rf_wdata", 32'(rf_wdata_OUT), 32'(e.d));
        end
      end
      if (pc_load_OUT) begin
        if (pc_q.size() == 0) chk("pc_unexpected_load", 32'(pc_load_OUT), 32'd0);
        else chk("pc_target", 32'(pc_target_OUT), 32'(pc_q.pop_front()));
      end
      for (int n = 0; n < 8; n++) exp_p[n] = (outst[n] > 0);
      chk("pending", 32'(pending_OUT), 32'(exp_p));
      chk("ready_vs_req", 32'(ready_OUT), 32'(!mem_req_OUT));
      chk("mem_err", 32'(mem_err_OUT), 32'(exp_err));
      p_acc  = valid_IN && ready_OUT;
      p_wren = wren_IN;
      p_wa   = writeAd_IN;
      p_rfwe = rf_we_OUT;
      p_rfa  = rf_waddr_OUT;
      p_req  = mem_req_OUT;
    end
  end

  initial begin
    int d, r;
    for (int n = 0; n < 8; n++) outst[n] = 0;
    p_acc = 0; p_wren = 0; p_rfwe = 0; p_req = 0; p_wa = '0; p_rfa = '0; mlen = 0; unstable = 0;

    #1 RST_N = 1'b0;
    #2;
    chk("rst_mem_req", 32'(mem_req_OUT), 32'd0);
    chk("rst_rf_we", 32'(rf_we_OUT), 32'd0);
    chk("rst_pc_load", 32'(pc_load_OUT), 32'd0);
    chk("rst_pending", 32'(pending_OUT), 32'd0);
    chk("rst_mem_err", 32'(mem_err_OUT), 32'd0);
    chk("rst_retire", 32'(retire_cnt_OUT), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ready", 32'(ready_OUT), 32'd1);
    mon_en = 1;

    issue(0, 1, 3'd5, 0, 0, 0, 8'h3C, 8'h00, 8'h00, 8'h00, 0); idle(); drain();
    chk("retire_after_alu", 32'(retire_cnt_OUT), 32'd1);
    issue(1, 1, 3'd1, 0, 0, 1, 8'h10, 8'hA5, 8'h00, 8'h00, 0); idle(); drain();
    issue(0, 1, 3'd3, 0, 1, 0, 8'h55, 8'h00, 8'h77, 8'h22, 3); idle(); drain();
    chk("retire_after_mem", 32'(retire_cnt_OUT), 32'd3);
    issue(0, 1, 3'd6, 1, 1, 1, 8'h91, 8'h00, 8'h44, 8'h08, -1); idle(); drain();
    chk("timeout_err_sticky", 32'(mem_err_OUT), 32'd1);
    chk("retire_after_timeout", 32'(retire_cnt_OUT), 32'd3);
    issue(0, 1, 3'd2, 0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 0);
    issue(0, 1, 3'd2, 0, 0, 0, 8'h22, 8'h00, 8'h00, 8'h00, 0); idle(); drain();
    issue(0, 1, 3'd7, 1, 1, 1, 8'hC4, 8'h00, 8'h5A, 8'h31, MEM_TIMEOUT - 1); idle(); drain();
    issue(1, 1, 3'd0, 0, 1, 0, 8'h19, 8'hE2, 8'h6B, 8'h40, MEM_TIMEOUT); idle(); drain();
    issue(0, 1, 3'd4, 1, 1, 0, 8'h2D, 8'h00, 8'h13, 8'h50, 0); idle(); drain();
    chk("retire_after_directed", 32'(retire_cnt_OUT), 32'(exp_retire));

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) d = $urandom_range(0, 4);
      else if (r == 6) d = MEM_TIMEOUT - 1;
      else if (r == 7) d = MEM_TIMEOUT;
      else if (r == 8) d = -1;
      else d = $urandom_range(5, 13);
      issue(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), d);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle(); drain();
    chk("retire_final", 32'(retire_cnt_OUT), 32'(exp_retire & 32'hFFFF));

    // Reset in the middle of an un-acked memory write.
    mon_en = 0;
    issue(0, 1, 3'd4, 0, 1, 0, 8'h66, 8'h00, 8'h99, 8'h12, -1); idle();
    repeat (3) @(posedge CLK);
    #3;
    chk("midwait_req", 32'(mem_req_OUT), 32'd1);
    chk("midwait_pending4", 32'(pending_OUT[4]), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_req_OUT), 32'd0);
    chk("rst_mid_pending", 32'(pending_OUT), 32'd0);
    chk("rst_mid_retire", 32'(retire_cnt_OUT), 32'd0);
    chk("rst_mid_err", 32'(mem_err_OUT), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_mid_ready", 32'(ready_OUT), 32'd1);
    chk("rst_mid_no_rf", 32'(rf_we_OUT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
